// File: rtl/hvac_scheduler.sv
// hvac_scheduler: drives the heating/cooling actuators from a 5-bit temperature
// code and a programmable setpoint.
// - A hysteresis band around the setpoint decides when a run starts.
// - A minimum run time and a post-run lockout stop the plant short-cycling.
// - Every output is a register decoded from the next state, so the outputs
//   change together with the state register.
module hvac_scheduler #(
    parameter int DEFAULT_SP = 20,
    parameter int HYST       = 2,
    parameter int MIN_RUN    = 8,
    parameter int MIN_OFF    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] temperature,
    input  logic       sp_wr,
    input  logic [4:0] sp_in,
    output logic [4:0] setpoint,
    output logic       heating,
    output logic       cooling,
    output logic       lockout,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAT    = 2'd1,
        COOL    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // The timer only has to reach the longer of the two hold times.
    // It saturates there.
    localparam int TMAX = ((MIN_RUN > MIN_OFF) ? MIN_RUN : MIN_OFF) - 1;
    localparam int TW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

    localparam logic [TW-1:0] TIMER_MAX = TW'(TMAX);
    localparam logic [TW-1:0] RUN_LAST  = TW'(MIN_RUN - 1);
    localparam logic [TW-1:0] OFF_LAST  = TW'(MIN_OFF - 1);

    // Clamp limits keep sp-HYST and sp+HYST inside 0..31.
    // The threshold arithmetic therefore never wraps.
    localparam logic [4:0] SP_MIN   = 5'(HYST);
    localparam logic [4:0] SP_MAX   = 5'(31 - HYST);
    localparam logic [4:0] SP_RESET = 5'(DEFAULT_SP);

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    sp_q, sp_d;
    logic          heating_q, cooling_q, lockout_q;

    logic [5:0] sp_ext, temp_ext, thr_low, thr_high;

    // The thresholds come from the registered setpoint.
    // A write on the same edge as a transition cannot affect that transition.
    assign sp_ext   = {1'b0, sp_q};
    assign temp_ext = {1'b0, temperature};
    assign thr_low  = sp_ext - 6'(HYST);
    assign thr_high = sp_ext + 6'(HYST);

    // Next-state decision for the actuator sequencer.
    always_comb begin
        // NOTE: default first so every path assigns state_d; otherwise a latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable && (temp_ext < thr_low)) begin
                    state_d = HEAT;
                end else if (enable && (temp_ext > thr_high)) begin
                    state_d = COOL;
                end
            end
            HEAT: begin
                if (!enable || ((timer_q >= RUN_LAST) && (temp_ext >= sp_ext))) begin
                    state_d = LOCKOUT;
                end
            end
            COOL: begin
                if (!enable || ((timer_q >= RUN_LAST) && (temp_ext <= sp_ext))) begin
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (timer_q == OFF_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Cycle count within the current state: it restarts at 0 on any state change.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Setpoint write path: the written value is clamped into the legal range.
    always_comb begin
        sp_d = sp_q;
        if (sp_wr) begin
            if (sp_in < SP_MIN) begin
                sp_d = SP_MIN;
            end else if (sp_in > SP_MAX) begin
                sp_d = SP_MAX;
            end else begin
                sp_d = sp_in;
            end
        end
    end

    // State, timer, setpoint and registered output decode.
    // Reset is synchronous and leaves no lockout pending.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked logic; every register samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            sp_q      <= SP_RESET;
            heating_q <= 1'b0;
            cooling_q <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            sp_q      <= sp_d;
            heating_q <= (state_d == HEAT);
            cooling_q <= (state_d == COOL);
            lockout_q <= (state_d == LOCKOUT);
        end
    end

    assign setpoint = sp_q;
    assign heating  = heating_q;
    assign cooling  = cooling_q;
    assign lockout  = lockout_q;
    assign state    = state_q;

endmodule

// File: tb/tb_hvac_scheduler.sv
// tb_hvac_scheduler: directed test-plan steps followed by a randomized phase.
// All outputs are compared each cycle against a cycle-level reference model.
// The model tracks the mode and an unbounded age counter in plain integers.
module tb_hvac_scheduler;

    localparam int DEF_SP  = 20;
    localparam int HYST    = 2;
    localparam int MIN_RUN = 8;
    localparam int MIN_OFF = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] temperature;
    logic       sp_wr;
    logic [4:0] sp_in;
    logic [4:0] setpoint;
    logic       heating;
    logic       cooling;
    logic       lockout;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0=idle, 1=heat, 2=cool, 3=lockout.
    // m_age counts edges spent in the mode.
    int m_mode;
    int m_age;
    int m_sp;

    always #5 clk = ~clk;

    hvac_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .temperature (temperature),
        .sp_wr       (sp_wr),
        .sp_in       (sp_in),
        .setpoint    (setpoint),
        .heating     (heating),
        .cooling     (cooling),
        .lockout     (lockout),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge, using the inputs present before that edge.
    task automatic model_edge();
        int t;
        int nxt;
        t = int'(temperature);
        if (rst) begin
            m_mode = 0;
            m_age  = 0;
            m_sp   = DEF_SP;
        end else begin
            nxt = m_mode;
            case (m_mode)
                0: begin
                    if (enable && t < m_sp - HYST)      nxt = 1;
                    else if (enable && t > m_sp + HYST) nxt = 2;
                end
                1: if (!enable || (m_age >= MIN_RUN - 1 && t >= m_sp)) nxt = 3;
                2: if (!enable || (m_age >= MIN_RUN - 1 && t <= m_sp)) nxt = 3;
                default: if (m_age == MIN_OFF - 1) nxt = 0;
            endcase
            if (sp_wr) begin
                if (int'(sp_in) < HYST)           m_sp = HYST;
                else if (int'(sp_in) > 31 - HYST) m_sp = 31 - HYST;
                else                              m_sp = int'(sp_in);
            end
            m_age  = (nxt == m_mode) ? m_age + 1 : 0;
            m_mode = nxt;
        end
    endtask

    // Clock n edges; after each edge, compare every output with the model.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("state",    32'(state),    32'(m_mode));
            chk("setpoint", 32'(setpoint), 32'(m_sp));
            chk("heating",  32'(heating),  32'(m_mode == 1));
            chk("cooling",  32'(cooling),  32'(m_mode == 2));
            chk("lockout",  32'(lockout),  32'(m_mode == 3));
        end
    endtask

    initial begin
        int n;
        m_mode      = 0;
        m_age       = 0;
        m_sp        = DEF_SP;
        rst         = 1'b1;
        enable      = 1'b0;
        temperature = 5'd20;
        sp_wr       = 1'b0;
        sp_in       = 5'd0;

        // Reset for two cycles.
        step(2);
        chk("reset_state",    32'(state),    0);
        chk("reset_setpoint", 32'(setpoint), 20);
        chk("reset_outputs",  32'({heating, cooling, lockout}), 0);
        rst = 1'b0;

        // Heat run: the minimum run time holds even after the target is reached.
        enable      = 1'b1;
        temperature = 5'd17;
        step(1);
        chk("heat_start", 32'(heating), 1);
        step(2);
        temperature = 5'd21;
        n = 3;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!heating) break;
            n++;
        end
        chk("heat_min_run", 32'(n), 8);
        chk("lockout_entry", 32'(lockout), 1);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (!lockout) break;
            n++;
        end
        chk("lockout_len", 32'(n), 6);
        chk("idle_after_lockout", 32'(state), 0);

        // The band edges themselves cause no actuation.
        temperature = 5'd18;
        step(10);
        chk("band_low_edge", 32'(state), 0);
        temperature = 5'd22;
        step(10);
        chk("band_high_edge", 32'(state), 0);
        temperature = 5'd23;
        step(1);
        chk("cool_start", 32'(cooling), 1);
        temperature = 5'd20;
        step(8);
        chk("cool_to_lockout", 32'(lockout), 1);
        step(6);
        chk("cool_lockout_done", 32'(state), 0);

        // Disable mid-run: go straight to lockout; temperature is ignored there.
        temperature = 5'd17;
        step(3);
        chk("heat_timer2", 32'(heating), 1);
        enable = 1'b0;
        step(1);
        chk("disable_lockout", 32'(state), 3);
        chk("disable_heat_off", 32'(heating), 0);
        temperature = 5'd25;
        step(5);
        chk("lockout_ignores_temp", 32'(cooling), 0);
        step(1);
        chk("disabled_idle", 32'(state), 0);
        enable = 1'b1;
        step(1);
        chk("cool_after_enable", 32'(cooling), 1);
        temperature = 5'd20;
        step(14);
        chk("back_to_idle", 32'(state), 0);

        // Setpoint clamp at both ends.
        enable = 1'b0;
        sp_wr  = 1'b1;
        sp_in  = 5'd30;
        step(1);
        chk("clamp_high", 32'(setpoint), 29);
        sp_in = 5'd0;
        step(1);
        chk("clamp_low", 32'(setpoint), 2);
        sp_in = 5'd30;
        step(1);
        sp_wr       = 1'b0;
        enable      = 1'b1;
        temperature = 5'd26;
        step(1);
        chk("heat_sp29", 32'(heating), 1);
        temperature = 5'd29;
        step(14);
        chk("sp29_idle", 32'(state), 0);

        // A write on a transition edge: the old threshold (low=27) decides.
        temperature = 5'd26;
        sp_wr       = 1'b1;
        sp_in       = 5'd20;
        step(1);
        sp_wr = 1'b0;
        chk("old_threshold_heat", 32'(heating), 1);
        chk("new_sp_visible", 32'(setpoint), 20);
        step(14);
        chk("write_edge_idle", 32'(state), 0);

        // Reset during COOL at timer=3.
        enable = 1'b0;
        sp_wr  = 1'b1;
        sp_in  = 5'd15;
        step(1);
        sp_wr       = 1'b0;
        enable      = 1'b1;
        temperature = 5'd25;
        step(4);
        chk("cool_before_rst", 32'(cooling), 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_cool_off",  32'(cooling),  0);
        chk("rst_state",     32'(state),    0);
        chk("rst_setpoint",  32'(setpoint), 20);
        chk("rst_no_lockout", 32'(lockout), 0);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 59) == 0);
            enable      = ($urandom_range(0, 9) != 0);
            temperature = 5'($urandom_range(0, 31));
            sp_wr       = ($urandom_range(0, 15) == 0);
            sp_in       = 5'($urandom_range(0, 31));
            step(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hvac_scheduler.md
Name: hvac_scheduler

Overview:
Sequences the heating/cooling actuators of the smart-home unit from a 5-bit temperature sample and a programmable setpoint.
- Applies a hysteresis band around the setpoint.
- Enforces a minimum actuator run time and a post-run compressor lockout, so the plant never short-cycles.
- Sits between the temperature sensor register and the AC outputs; the lighting path is untouched.

Parameters:
- DEFAULT_SP, 20, setpoint loaded on reset (units of the temperature code).
- HYST, 2, half-width of the dead band; low = sp-HYST, high = sp+HYST.
- MIN_RUN, 8, minimum cycles heating/cooling stays asserted once started (>=1).
- MIN_OFF, 6, cycles of forced lockout after any heat/cool run ends (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  1 = automatic climate control permitted.
- temperature  input  5  current temperature code, sampled every edge.
- sp_wr  input  1  setpoint write strobe, one cycle.
- sp_in  input  5  setpoint value written when sp_wr=1.
- setpoint  output  5  current stored (clamped) setpoint.
- heating  output  1  heater drive.
- cooling  output  1  cooler drive.
- lockout  output  1  high while in LOCKOUT.
- state  output  2  IDLE=0, HEAT=1, COOL=2, LOCKOUT=3.

Behaviour:
- Reset, synchronous: state=IDLE, timer=0, setpoint=DEFAULT_SP, heating=cooling=lockout=0.
- All outputs are registered and decoded from the state register:
  - heating=(state==HEAT), cooling=(state==COOL), lockout=(state==LOCKOUT).
  - heating and cooling are never both 1.
- Setpoint write:
  - On sp_wr, setpoint <= clamp(sp_in, HYST, 31-HYST).
  - The new value is visible one cycle later.
  - Thresholds on the edge of the write still use the old setpoint.
- Thresholds are computed combinationally from the registered setpoint at 6-bit width. Clamping guarantees no wrap.
- Timer: counts cycles in the current state. It is 0 on the first cycle after entering any state and saturates at max(MIN_RUN, MIN_OFF)-1.
- IDLE:
  - enable=1 and temperature < sp-HYST: go to HEAT.
  - enable=1 and temperature > sp+HYST: go to COOL.
  - Otherwise stay in IDLE. Band edges themselves (== low, == high) cause no action.
  - enable=0: stay in IDLE.
- HEAT:
  - enable=0: go to LOCKOUT on the next edge, regardless of timer.
  - timer >= MIN_RUN-1 and temperature >= sp: go to LOCKOUT.
  - Otherwise stay in HEAT. Heating therefore lasts at least MIN_RUN cycles unless disabled.
- COOL: symmetric to HEAT; the exit condition is temperature <= sp.
- LOCKOUT:
  - Temperature and enable are ignored.
  - Leave to IDLE when timer == MIN_OFF-1, giving exactly MIN_OFF cycles with lockout=1.
  - There is no direct HEAT<->COOL path; a reversal always passes through LOCKOUT and IDLE.
- Latency: the temperature sampled at edge N is reflected on heating/cooling after edge N, i.e. one cycle.
- rst mid-operation: outputs drop at the reset edge; no lockout is imposed afterwards.
- Simultaneous sp_wr and a state transition: the transition uses the pre-write setpoint.

Test Plan (defaults: SP=20, low=18, high=22):
- Reset: assert rst 2 cycles -> state=0, setpoint=20, heating=cooling=lockout=0.
- Heat run, minimum run time: enable=1, temperature=17 -> heating=1 on the next edge.
  - Temperature=21 at heat cycle 3 -> heating stays 1 until 8 cycles total.
  - Then lockout=1 for exactly 6 cycles, then state=IDLE.
- Band edges: temperature=18 and temperature=22 for 10 cycles each -> no actuation.
  - Temperature=23 -> cooling=1 next edge.
  - Temperature=20 after the minimum run -> 6-cycle lockout.
- Disable mid-run: in HEAT at timer=2, enable=0 -> state=LOCKOUT next edge, heating=0.
  - Temperature=25 during lockout -> no cooling until lockout completes and enable=1.
- Setpoint clamp: sp_wr with sp_in=30 -> setpoint=29; with sp_in=0 -> setpoint=2.
  - Setpoint=29, temperature=26 -> heating=1 (low=27).
  - Write on a transition edge -> the old threshold is used.
- Reset mid-COOL: rst during COOL at timer=3 -> cooling=0, state=IDLE, setpoint=20 on the next edge, lockout=0.
